sw_array_feeder: RTL



---
 rtl/sw_pkg.sv | 23 ++
 rtl/sw_base_fifo.sv | 70 +++++++
 rtl/sw_array_feeder.sv | 187 ++++++++++++++++++
 3 files changed

// File: rtl/sw_pkg.sv
// Shared definitions for the Smith-Waterman array: base encoding, the feeder
// state machine encoding and the negative-infinity score used at both chain ends.
package sw_pkg;

    localparam logic [1:0] BASE_A = 2'd0;
    localparam logic [1:0] BASE_C = 2'd1;
    localparam logic [1:0] BASE_G = 2'd2;
    localparam logic [1:0] BASE_T = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD_Q   = 3'd1,
        ST_WAIT_REF = 3'd2,
        ST_STREAM   = 3'd3,
        ST_DRAIN    = 3'd4
    } state_t;

    // Far enough below zero that adding gap penalties never wraps positive.
    function automatic int NEG_INF(input int width);
        return -(1 << (width - 2));
    endfunction

endpackage

// File: rtl/sw_base_fifo.sv
// Reference base FIFO: each entry is {last, base}. Read data is presented
// from the head entry without a pop, so the consumer sees it the same cycle.
module sw_base_fifo #(
    parameter int DEPTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [2:0]               din,
    input  logic                     pop,
    output logic [2:0]               dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic [2:0]    mem_q [DEPTH];
    logic          do_push, do_pop;

    // A push into a full FIFO is legal when the same cycle frees a slot.
    assign do_pop  = pop && (count_q != '0);
    assign do_push = push && ((count_q != FULL_CNT) || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (clr) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clr) mem_q[wr_ptr_q] <= din;
    end

    assign dout  = mem_q[rd_ptr_q];
    assign count = count_q;
    assign full  = (count_q == FULL_CNT);
    assign empty = (count_q == '0);

endmodule

// File: rtl/sw_array_feeder.sv
// Head-of-array sequencer for the Smith-Waterman PE chain: loads the query,
// streams reference bases through a prefill FIFO, drains the chain and reports.
module sw_array_feeder
    import sw_pkg::*;
#(
    parameter int WIDTH      = 10,
    parameter int NUM_PE     = 64,
    parameter int FIFO_DEPTH = 16,
    parameter int PREFILL    = 8,
    parameter int LEN_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             q_valid,
    output logic             q_ready,
    input  logic [1:0]       q_base,
    input  logic             r_valid,
    output logic             r_ready,
    input  logic [1:0]       r_base,
    input  logic             r_last,
    output logic [WIDTH-1:0] V_out,
    output logic [WIDTH-1:0] F_out,
    output logic [1:0]       S_out,
    output logic             store_S_out,
    output logic [1:0]       T_out,
    output logic             init_out,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [LEN_W-1:0] ref_len
);
    localparam int QCW = $clog2(NUM_PE + 1);
    localparam int DCW = $clog2(NUM_PE + 2);
    localparam int CW  = $clog2(FIFO_DEPTH) + 1;
    localparam logic [QCW-1:0]   Q_LAST  = QCW'(NUM_PE - 1);
    localparam logic [DCW-1:0]   D_LAST  = DCW'(NUM_PE);
    localparam logic [CW-1:0]    PF_CNT  = CW'(PREFILL);
    localparam logic [LEN_W-1:0] LEN_MAX = '1;

    state_t           state_q, state_d;
    logic [QCW-1:0]   q_cnt_q, q_cnt_d;
    logic [DCW-1:0]   drain_cnt_q, drain_cnt_d;
    logic [1:0]       s_q, s_d;
    logic             store_s_q, store_s_d;
    logic [1:0]       t_q, t_d;
    logic             init_q, init_d;
    logic             done_q, done_d;
    logic             err_q, err_d;
    logic [LEN_W-1:0] ref_len_q, ref_len_d;
    logic             last_seen_q, last_seen_d;

    logic             q_hs, r_hs, pop, intake, fifo_clr;
    logic [2:0]       fifo_dout;
    logic [CW-1:0]    fifo_count;
    logic             fifo_full, fifo_empty;
    logic [LEN_W-1:0] ref_len_inc;

    assign intake      = (state_q == ST_WAIT_REF) || (state_q == ST_STREAM);
    assign pop         = (state_q == ST_STREAM) && !fifo_empty;
    assign q_ready     = (state_q == ST_LOAD_Q);
    assign r_ready     = intake && !last_seen_q && (!fifo_full || pop);
    assign q_hs        = q_valid && q_ready;
    assign r_hs        = r_valid && r_ready;
    assign ref_len_inc = ref_len_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        q_cnt_d     = q_cnt_q;
        drain_cnt_d = drain_cnt_q;
        s_d         = s_q;
        store_s_d   = 1'b0;
        t_d         = t_q;
        init_d      = 1'b0;
        done_d      = 1'b0;
        err_d       = err_q;
        ref_len_d   = ref_len_q;
        last_seen_d = last_seen_q;
        fifo_clr    = 1'b0;

        if (r_hs && r_last) last_seen_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d     = ST_LOAD_Q;
                    q_cnt_d     = '0;
                    drain_cnt_d = '0;
                    ref_len_d   = '0;
                    err_d       = 1'b0;
                    last_seen_d = 1'b0;
                    fifo_clr    = 1'b1;
                end
            end
            ST_LOAD_Q: begin
                if (q_hs) begin
                    s_d       = q_base;
                    store_s_d = 1'b1;
                    q_cnt_d   = q_cnt_q + 1'b1;
                    if (q_cnt_q == Q_LAST) state_d = ST_WAIT_REF;
                end
            end
            ST_WAIT_REF: begin
                // A short job whose last base is already queued skips the prefill.
                if ((fifo_count >= PF_CNT) || last_seen_q) state_d = ST_STREAM;
            end
            ST_STREAM: begin
                if (pop) begin
                    t_d       = fifo_dout[1:0];
                    init_d    = 1'b1;
                    ref_len_d = ref_len_inc;
                    if (ref_len_inc == LEN_MAX) err_d = 1'b1;
                    if (fifo_dout[2] || (ref_len_inc == LEN_MAX)) state_d = ST_DRAIN;
                end else begin
                    // The chain cannot stall, so an empty FIFO truncates the job.
                    err_d   = 1'b1;
                    state_d = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (done_q) begin
                    state_d = ST_IDLE;
                end else if (drain_cnt_q == D_LAST) begin
                    done_d = 1'b1;
                end else begin
                    drain_cnt_d = drain_cnt_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            q_cnt_q     <= '0;
            drain_cnt_q <= '0;
            s_q         <= BASE_A;
            store_s_q   <= 1'b0;
            t_q         <= BASE_A;
            init_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            ref_len_q   <= '0;
            last_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            q_cnt_q     <= q_cnt_d;
            drain_cnt_q <= drain_cnt_d;
            s_q         <= s_d;
            store_s_q   <= store_s_d;
            t_q         <= t_d;
            init_q      <= init_d;
            done_q      <= done_d;
            err_q       <= err_d;
            ref_len_q   <= ref_len_d;
            last_seen_q <= last_seen_d;
        end
    end

    sw_base_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .clr   (fifo_clr),
        .push  (r_hs),
        .din   ({r_last, r_base}),
        .pop   (pop),
        .dout  (fifo_dout),
        .count (fifo_count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign V_out       = '0;
    assign F_out       = WIDTH'(NEG_INF(WIDTH));
    assign S_out       = s_q;
    assign store_S_out = store_s_q;
    assign T_out       = t_q;
    assign init_out    = init_q;
    assign busy        = (state_q != ST_IDLE);
    assign done        = done_q;
    assign err         = err_q;
    assign ref_len     = ref_len_q;

endmodule
